// File: rtl/ahb_lite_slave_bridge_if.sv
// AHB-Lite slave port plus local register-bus signals for the bridge.
// The slave modport is the bridge side; master is the bus/peripheral side.
interface ahb_lite_slave_bridge_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [3:0]        HPROT;
    logic              HMASTLOCK;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic              HREADYOUT;
    logic              HRESP;
    logic [DATA_W-1:0] HRDATA;

    logic                lb_req;
    logic                lb_we;
    logic [ADDR_W-1:0]   lb_addr;
    logic [DATA_W/8-1:0] lb_be;
    logic [DATA_W-1:0]   lb_wdata;
    logic                lb_ack;
    logic                lb_err;
    logic [DATA_W-1:0]   lb_rdata;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE,
        input  HBURST, HPROT, HMASTLOCK, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA,
        output lb_req, lb_we, lb_addr, lb_be, lb_wdata,
        input  lb_ack, lb_err, lb_rdata
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE,
        output HBURST, HPROT, HMASTLOCK, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA,
        input  lb_req, lb_we, lb_addr, lb_be, lb_wdata,
        output lb_ack, lb_err, lb_rdata
    );
endinterface

// File: rtl/ahb_lite_slave_bridge.sv
// AHB-Lite slave terminating each transfer as one req/ack local-bus access,
// with byte enables, alignment/size checks and an access timeout.
module ahb_lite_slave_bridge #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input logic HCLK,
    input logic HRESET,
    ahb_lite_slave_bridge_if.slave bus
);
    localparam int NB = DATA_W / 8;
    localparam int LG = $clog2(NB);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t            state;
    state_t            nxt;
    logic              hready_q;
    logic              hresp_q;
    logic [DATA_W-1:0] hrdata_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [NB-1:0]     be_q;
    logic [7:0]        cnt;

    logic              open_st;
    logic              accept;
    logic              size_ok;
    logic              aligned;
    logic              legal;
    logic              timeout;
    logic [ADDR_W-1:0] amask;
    logic [NB-1:0]     be_nx;
    int                lane;
    int                span;

    logic unused_ins;
    assign unused_ins = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK};

    always_comb begin
        open_st = (state == S_IDLE) || (state == S_DONE) ||
                  (state == S_ERR2);
        accept  = open_st && bus.HSEL && bus.HREADY && bus.HTRANS[1];
        size_ok = bus.HSIZE <= 3'(LG);
        amask   = ~({ADDR_W{1'b1}} << bus.HSIZE);
        aligned = (bus.HADDR & amask) == '0;
        legal   = size_ok && aligned;
        timeout = cnt == 8'(MAX_WAIT - 1);
    end

    // Little-endian lanes: 2^HSIZE bytes starting at the low address bits.
    always_comb begin
        be_nx = '0;
        lane  = int'(bus.HADDR[LG-1:0]);
        span  = 1 << bus.HSIZE;
        for (int i = 0; i < NB; i++) begin
            if (i >= lane && i < lane + span) begin
                be_nx[i] = 1'b1;
            end
        end
    end

    always_comb begin
        nxt = S_IDLE;
        case (state)
            S_IDLE, S_DONE, S_ERR2: begin
                if (accept) begin
                    nxt = legal ? S_ACCESS : S_ERR1;
                end
            end
            S_ACCESS: begin
                if (bus.lb_ack) begin
                    nxt = bus.lb_err ? S_ERR1 : S_DONE;
                end else if (timeout) begin
                    nxt = S_ERR1;
                end else begin
                    nxt = S_ACCESS;
                end
            end
            S_ERR1:  nxt = S_ERR2;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state    <= S_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
            hrdata_q <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            cnt      <= '0;
        end else begin
            state    <= nxt;
            hready_q <= (nxt == S_IDLE) || (nxt == S_DONE) ||
                        (nxt == S_ERR2);
            hresp_q  <= (nxt == S_ERR1) || (nxt == S_ERR2);
            req_q    <= nxt == S_ACCESS;
            // Any entry into ACCESS comes from a non-ACCESS state.
            cnt      <= (state == S_ACCESS) ? cnt + 8'd1 : 8'd0;
            if (accept) begin
                addr_q <= bus.HADDR;
                we_q   <= bus.HWRITE;
                be_q   <= be_nx;
            end
            if (state == S_ACCESS && bus.lb_ack &&
                !bus.lb_err && !we_q) begin
                hrdata_q <= bus.lb_rdata;
            end
        end
    end

    assign bus.HREADYOUT = hready_q;
    assign bus.HRESP     = hresp_q;
    assign bus.HRDATA    = hrdata_q;
    assign bus.lb_req    = req_q;
    assign bus.lb_we     = we_q;
    assign bus.lb_addr   = addr_q;
    assign bus.lb_be     = be_q;
    assign bus.lb_wdata  = bus.HWDATA;
endmodule

// File: tb/tb_ahb_lite_slave_bridge.sv
// Scoreboard bench: stimulus queues expected responses, a monitor checks
// each completed data phase against them.
module tb_ahb_lite_slave_bridge;
    logic HCLK;
    logic HRESET;

    ahb_lite_slave_bridge_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    ahb_lite_slave_bridge #(
        .ADDR_W(8),
        .DATA_W(32),
        .MAX_WAIT(15)
    ) dut (
        .HCLK(HCLK),
        .HRESET(HRESET),
        .bus(bus.slave)
    );

    assign bus.HREADY = bus.HREADYOUT;

    typedef struct {
        logic        resp;
        logic [31:0] rdata;
        logic        chk_rd;
        int          waits;
        int          reqc;
        logic        chk_lb;
        logic        we;
        logic [3:0]  be;
        logic [7:0]  addr;
    } exp_t;

    exp_t        q[$];
    int          vectors;
    int          miscompares;
    logic        spur;
    logic [31:0] mem [0:63];

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic exp_t mk(input logic resp, input logic [31:0] rd,
                                input logic chk_rd, input int waits,
                                input int reqc, input logic chk_lb,
                                input logic we, input logic [3:0] be,
                                input logic [7:0] addr);
        exp_t e;
        e.resp   = resp;
        e.rdata  = rd;
        e.chk_rd = chk_rd;
        e.waits  = waits;
        e.reqc   = reqc;
        e.chk_lb = chk_lb;
        e.we     = we;
        e.be     = be;
        e.addr   = addr;
        return e;
    endfunction

    // Local-bus responder: 0x14 never acks, 0x18 errors, 0x1C acks late.
    initial begin
        int          rcnt;
        int          dly;
        logic [31:0] w;
        rcnt = 0;
        forever begin
            @(negedge HCLK);
            bus.lb_ack = 1'b0;
            bus.lb_err = 1'b0;
            if (spur) begin
                bus.lb_ack   = 1'b1;
                bus.lb_rdata = 32'h12345678;
            end else if (HRESET && bus.lb_req) begin
                dly = (bus.lb_addr == 8'h1C) ? 3 : 0;
                if (bus.lb_addr != 8'h14 && rcnt == dly) begin
                    bus.lb_ack   = 1'b1;
                    bus.lb_err   = bus.lb_addr == 8'h18;
                    w            = mem[bus.lb_addr[7:2]];
                    bus.lb_rdata = w;
                    if (bus.lb_we && !bus.lb_err) begin
                        for (int b = 0; b < 4; b++) begin
                            if (bus.lb_be[b]) w[8*b +: 8] = bus.lb_wdata[8*b +: 8];
                        end
                        mem[bus.lb_addr[7:2]] = w;
                    end
                end
                rcnt++;
            end else begin
                rcnt = 0;
            end
        end
    end

    // Monitor: tracks each accepted transfer through its data phase.
    initial begin
        logic in_data;
        logic low_resp;
        int   waits;
        int   reqc;
        exp_t e;
        in_data  = 1'b0;
        low_resp = 1'b0;
        waits    = 0;
        reqc     = 0;
        forever begin
            @(negedge HCLK);
            if (!HRESET) begin
                in_data = 1'b0;
            end else begin
                if (in_data) begin
                    if (bus.lb_req) reqc++;
                    if (!bus.HREADYOUT) begin
                        waits++;
                        low_resp = bus.HRESP;
                    end else begin
                        in_data = 1'b0;
                        if (q.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected_completion: got resp %0d expected none",
                                     bus.HRESP);
                        end else begin
                            e = q.pop_front();
                            check("hresp", 32'(bus.HRESP), 32'(e.resp));
                            check("wait_states", 32'(waits), 32'(e.waits));
                            check("req_cycles", 32'(reqc), 32'(e.reqc));
                            if (e.resp) check("err1_resp", 32'(low_resp), 32'd1);
                            if (e.chk_rd) check("hrdata", bus.HRDATA, e.rdata);
                            if (e.chk_lb) begin
                                check("lb_we", 32'(bus.lb_we), 32'(e.we));
                                check("lb_be", 32'(bus.lb_be), 32'(e.be));
                                check("lb_addr", 32'(bus.lb_addr), 32'(e.addr));
                            end
                        end
                    end
                end
                if (bus.HSEL && bus.HREADY && bus.HTRANS[1]) begin
                    in_data  = 1'b1;
                    waits    = 0;
                    reqc     = 0;
                    low_resp = 1'b0;
                end
            end
        end
    end

    task automatic xfer(input logic [7:0] a, input logic [2:0] sz,
                        input logic w, input logic [31:0] wd,
                        input exp_t e, input bit push);
        int n;
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR  = a;
        bus.HSIZE  = sz;
        bus.HWRITE = w;
        n = 0;
        while (!bus.HREADYOUT && n < 100) begin
            @(posedge HCLK);
            #1;
            n++;
        end
        if (n >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL xfer_stall: got HREADYOUT 0 for %0d cycles expected 1", n);
        end
        if (push) q.push_back(e);
        @(posedge HCLK);
        #1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWDATA = wd;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || !bus.HREADYOUT) && n < 200) begin
            @(posedge HCLK);
            #1;
            n++;
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        exp_t nul;
        vectors     = 0;
        miscompares = 0;
        spur        = 1'b0;
        nul         = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        HRESET        = 1'b0;
        bus.HSEL      = 1'b0;
        bus.HADDR     = '0;
        bus.HTRANS    = 2'b00;
        bus.HWRITE    = 1'b0;
        bus.HSIZE     = 3'd0;
        bus.HBURST    = 3'd0;
        bus.HPROT     = 4'd0;
        bus.HMASTLOCK = 1'b0;
        bus.HWDATA    = '0;
        bus.lb_ack    = 1'b0;
        bus.lb_err    = 1'b0;
        bus.lb_rdata  = '0;

        repeat (2) @(posedge HCLK);
        #1;
        check("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        check("rst_hresp", 32'(bus.HRESP), 32'd0);
        check("rst_hrdata", bus.HRDATA, 32'd0);
        check("rst_lb_req", 32'(bus.lb_req), 32'd0);
        check("rst_lb_we", 32'(bus.lb_we), 32'd0);
        check("rst_lb_addr", 32'(bus.lb_addr), 32'd0);
        check("rst_lb_be", 32'(bus.lb_be), 32'd0);
        #2 HRESET = 1'b1;
        @(posedge HCLK);
        #1;

        // Word write then read
        xfer(8'h10, 3'd2, 1'b1, 32'hDEADBEEF,
             mk(0, 0, 0, 1, 1, 1, 1, 4'hF, 8'h10), 1);
        drain();
        xfer(8'h10, 3'd2, 1'b0, 32'h0,
             mk(0, 32'hDEADBEEF, 1, 1, 1, 1, 0, 4'hF, 8'h10), 1);
        drain();

        // Subword writes, then read back merged word
        xfer(8'h13, 3'd0, 1'b1, 32'hAA000000,
             mk(0, 0, 0, 1, 1, 1, 1, 4'b1000, 8'h13), 1);
        drain();
        xfer(8'h12, 3'd1, 1'b1, 32'h55660000,
             mk(0, 0, 0, 1, 1, 1, 1, 4'b1100, 8'h12), 1);
        drain();
        xfer(8'h10, 3'd2, 1'b0, 32'h0,
             mk(0, 32'h5566BEEF, 1, 1, 1, 1, 0, 4'hF, 8'h10), 1);
        drain();

        // Misaligned and oversize
        xfer(8'h11, 3'd2, 1'b1, 32'h0,
             mk(1, 0, 0, 1, 0, 0, 0, 0, 0), 1);
        drain();
        xfer(8'h10, 3'd3, 1'b0, 32'h0,
             mk(1, 0, 0, 1, 0, 0, 0, 0, 0), 1);
        drain();

        // Delayed ack: 4 wait states
        xfer(8'h1C, 3'd2, 1'b1, 32'hCAFEF00D,
             mk(0, 0, 0, 4, 4, 1, 1, 4'hF, 8'h1C), 1);
        drain();
        xfer(8'h1C, 3'd2, 1'b0, 32'h0,
             mk(0, 32'hCAFEF00D, 1, 4, 4, 1, 0, 4'hF, 8'h1C), 1);
        drain();

        // Timeout: 15 req cycles plus ERR1
        xfer(8'h14, 3'd2, 1'b0, 32'h0,
             mk(1, 0, 0, 16, 15, 1, 0, 4'hF, 8'h14), 1);
        drain();
        spur = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        spur = 1'b0;
        check("late_ack_hrdata", bus.HRDATA, 32'hCAFEF00D);
        check("late_ack_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        check("late_ack_hresp", 32'(bus.HRESP), 32'd0);

        // Local error, then a read issued into the error response
        xfer(8'h18, 3'd2, 1'b1, 32'h11111111,
             mk(1, 0, 0, 2, 1, 1, 1, 4'hF, 8'h18), 1);
        xfer(8'h10, 3'd2, 1'b0, 32'h0,
             mk(0, 32'h5566BEEF, 1, 1, 1, 1, 0, 4'hF, 8'h10), 1);
        drain();

        // Back-to-back NONSEQ write and read
        xfer(8'h20, 3'd2, 1'b1, 32'h01020304,
             mk(0, 0, 0, 1, 1, 1, 1, 4'hF, 8'h20), 1);
        xfer(8'h20, 3'd2, 1'b0, 32'h0,
             mk(0, 32'h01020304, 1, 1, 1, 1, 0, 4'hF, 8'h20), 1);
        drain();

        // Reset while waiting in ACCESS
        xfer(8'h14, 3'd2, 1'b0, 32'h0, nul, 0);
        repeat (3) @(posedge HCLK);
        #2;
        check("pre_reset_lb_req", 32'(bus.lb_req), 32'd1);
        HRESET = 1'b0;
        #1;
        check("mid_reset_lb_req", 32'(bus.lb_req), 32'd0);
        check("mid_reset_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        check("mid_reset_hrdata", bus.HRDATA, 32'd0);
        @(posedge HCLK);
        @(posedge HCLK);
        #3 HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        xfer(8'h10, 3'd2, 1'b0, 32'h0,
             mk(0, 32'h5566BEEF, 1, 1, 1, 1, 0, 4'hF, 8'h10), 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
